// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with an in-order response FIFO and redirect flush.
// Define FETCH_PERF_CNT_EN to build the fetch-starvation counter driving stall_cycles_out.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  output logic        imem_req_valid_out,
  output logic [31:0] imem_req_addr_out,
  input  logic        imem_req_ready_in,
  input  logic        imem_resp_valid_in,
  input  logic [31:0] imem_resp_data_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        inst_valid_out,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  input  logic        inst_ready_in,
  output logic [31:0] stall_cycles_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_e;
  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   inst_mem_q [FIFO_DEPTH];
  logic [31:0]   pc_mem_q [FIFO_DEPTH];
  logic          credit_ok, req_fire, resp_dec, push, pop;
  logic [31:0]   redirect_pc;
  // Outstanding requests plus buffered entries never exceed the FIFO, so responses always fit.
  assign credit_ok          = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid_out = (state_q == FETCH) && !redirect_valid_in && credit_ok;
  assign imem_req_addr_out  = fetch_pc_q;
  assign req_fire           = imem_req_valid_out && imem_req_ready_in;
  assign resp_dec           = imem_resp_valid_in && (outstanding_q != '0);
  assign push               = (state_q == FETCH) && !redirect_valid_in && resp_dec;
  assign pop                = inst_valid_out && inst_ready_in && !redirect_valid_in;
  assign redirect_pc        = {redirect_pc_in[31:2], 2'b00};
  assign inst_valid_out     = count_q != '0;
  assign instruction_out    = inst_mem_q[rd_ptr_q];
  assign pc_out             = pc_mem_q[rd_ptr_q];
  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_dec);
    count_d       = count_q + CW'(push) - CW'(pop);
    wr_ptr_d      = wr_ptr_q + AW'(push);
    rd_ptr_d      = rd_ptr_q + AW'(pop);
    fetch_pc_d    = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d     = push ? resp_pc_q + 32'd4 : resp_pc_q;
    drop_cnt_d    = (state_q == FLUSH) ? drop_cnt_q - CW'(resp_dec) : drop_cnt_q;
    state_d       = (state_q == IDLE) ? FETCH :
                    (state_q == FLUSH && drop_cnt_d == '0) ? FETCH : state_q;
    if (redirect_valid_in) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_cnt_d = (state_q == FLUSH) ? drop_cnt_d : outstanding_d;
      state_d    = (drop_cnt_d == '0) ? FETCH : FLUSH;
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= imem_resp_data_in;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  assign stall_d = (state_q == FETCH && !inst_valid_out && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cycles_out = stall_q;
`else
  assign stall_cycles_out = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand-written redirect/reset/counter sequences for fetch_unit.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid_out;
  logic [31:0] imem_req_addr_out;
  logic        imem_req_ready_in = 1'b0;
  logic        imem_resp_valid_in = 1'b0;
  logic [31:0] imem_resp_data_in = '0;
  logic        redirect_valid_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  logic        inst_valid_out;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        inst_ready_in = 1'b0;
  logic [31:0] stall_cycles_out;
  logic        resp_en = 1'b0;
  logic [31:0] q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic        rdy;
    logic        irdy;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[13];

  fetch_unit dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .imem_req_valid_out(imem_req_valid_out), .imem_req_addr_out(imem_req_addr_out),
    .imem_req_ready_in(imem_req_ready_in),
    .imem_resp_valid_in(imem_resp_valid_in), .imem_resp_data_in(imem_resp_data_in),
    .redirect_valid_in(redirect_valid_in), .redirect_pc_in(redirect_pc_in),
    .inst_valid_out(inst_valid_out), .instruction_out(instruction_out), .pc_out(pc_out),
    .inst_ready_in(inst_ready_in), .stall_cycles_out(stall_cycles_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string name, input logic [31:0] pc);
    chk({name, ".iv"}, 32'(inst_valid_out), 32'd1);
    chk({name, ".pc"}, pc_out, pc);
    chk({name, ".inst"}, instruction_out, word(pc));
  endtask

  // Latency-1 in-order memory: a request accepted at an edge is presented the next cycle when resp_en.
  task automatic step();
    logic fired, pres;
    logic [31:0] a;
    #1;
    fired = imem_req_valid_out && imem_req_ready_in;
    a = imem_req_addr_out;
    pres = imem_resp_valid_in;
    @(posedge clk);
    #1;
    if (pres) void'(q.pop_front());
    if (fired) q.push_back(a);
    imem_resp_valid_in = resp_en && q.size() > 0;
    imem_resp_data_in = imem_resp_valid_in ? word(q[0]) : 32'h0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid_in = 1'b0;
    imem_req_ready_in = 1'b0;
    inst_ready_in = 1'b0;
    resp_en = 1'b0;
    imem_resp_valid_in = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic build_two_outstanding();
    do_reset();
    imem_req_ready_in = 1'b1;
    step();
    step();
    step();
    imem_req_ready_in = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_stall;
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h08};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};

    do_reset();
    chk("reset.rv", 32'(imem_req_valid_out), 32'd0);
    chk("reset.iv", 32'(inst_valid_out), 32'd0);
    chk("reset.stall", stall_cycles_out, 32'd0);

    resp_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      imem_req_ready_in = tbl[i].rdy;
      inst_ready_in = tbl[i].irdy;
      #1;
      chk($sformatf("v%0d.rv", i), 32'(imem_req_valid_out), 32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv) chk($sformatf("v%0d.addr", i), imem_req_addr_out, tbl[i].exp_addr);
      chk($sformatf("v%0d.iv", i), 32'(inst_valid_out), 32'(tbl[i].exp_iv));
      if (tbl[i].exp_iv) begin
        chk($sformatf("v%0d.pc", i), pc_out, tbl[i].exp_pc);
        chk($sformatf("v%0d.inst", i), instruction_out, word(tbl[i].exp_pc));
      end
      if (i < 12) step();
    end

    // Asynchronous reset with the FIFO full
    rst_n = 1'b0;
    #1;
    chk("async_rst.iv", 32'(inst_valid_out), 32'd0);
    chk("async_rst.rv", 32'(imem_req_valid_out), 32'd0);
    chk("async_rst.stall", stall_cycles_out, 32'd0);
    do_reset();
    imem_req_ready_in = 1'b1;
    step();
    chk("post_rst.rv", 32'(imem_req_valid_out), 32'd1);
    chk("post_rst.addr", imem_req_addr_out, 32'h0);

    // Redirect to 0x103 with two responses outstanding
    build_two_outstanding();
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'h103;
    resp_en = 1'b1;
    imem_req_ready_in = 1'b1;
    #1;
    chk("rd1.rv_during", 32'(imem_req_valid_out), 32'd0);
    step();
    redirect_valid_in = 1'b0;
    #1;
    chk("rd1.state", 32'(int'(dut.state_q)), 32'd2);
    chk("rd1.iv", 32'(inst_valid_out), 32'd0);
    chk("rd1.rv_flush", 32'(imem_req_valid_out), 32'd0);
    step();
    chk("rd1.rv_flush2", 32'(imem_req_valid_out), 32'd0);
    step();
    chk("rd1.rv", 32'(imem_req_valid_out), 32'd1);
    chk("rd1.addr", imem_req_addr_out, 32'h100);
    chk("rd1.iv_nodrop", 32'(inst_valid_out), 32'd0);
    step();
    chk("rd1.iv_wait", 32'(inst_valid_out), 32'd0);
    step();
    chk_head("rd1.head", 32'h100);

    // Redirect inside FLUSH while one drop remains
    build_two_outstanding();
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'h100;
    resp_en = 1'b1;
    step();
    redirect_valid_in = 1'b0;
    resp_en = 1'b0;
    step();
    chk("rd2.drop", 32'(dut.drop_cnt_q), 32'd1);
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'h200;
    resp_en = 1'b1;
    imem_req_ready_in = 1'b1;
    step();
    redirect_valid_in = 1'b0;
    #1;
    chk("rd2.state", 32'(int'(dut.state_q)), 32'd2);
    chk("rd2.rv_flush", 32'(imem_req_valid_out), 32'd0);
    step();
    chk("rd2.rv", 32'(imem_req_valid_out), 32'd1);
    chk("rd2.addr", imem_req_addr_out, 32'h200);
    step();
    step();
    chk_head("rd2.head", 32'h200);

    // Starvation counter with memory held not-ready, address held stable
    do_reset();
    step();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d.addr", i), imem_req_addr_out, 32'h0);
      step();
    end
`ifdef FETCH_PERF_CNT_EN
    exp_stall = 32'd10;
`else
    exp_stall = 32'd0;
`endif
    chk("stall", stall_cycles_out, exp_stall);

    // Address wrap from 0xFFFF_FFFC to 0
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'hFFFF_FFFF;
    step();
    redirect_valid_in = 1'b0;
    imem_req_ready_in = 1'b1;
    resp_en = 1'b1;
    inst_ready_in = 1'b0;
    #1;
    chk("wrap.addr0", imem_req_addr_out, 32'hFFFF_FFFC);
    step();
    chk("wrap.addr1", imem_req_addr_out, 32'h0);
    step();
    chk_head("wrap.head", 32'hFFFF_FFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
